pm_sched: RTL and testbench

Parametrised, clocked successor to the flat pm-class mode decoder. It turns the enable/lock/mode gating that the combinational version decodes once per evaluation into an N-channel request scheduler. The scheduler has a grant state machine, a per-grant hold counter, timeout and protocol-error reporting, and selectable arbitration modes. It sits between channel requesters and a shared resource in the benchmark control path.

---
 rtl/pm_sched_pkg.sv | 15 +
 rtl/pm_rr_pick.sv | 32 +++
 rtl/pm_sched.sv | 148 ++++++++++++++
 tb/tb_pm_sched.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/pm_sched_pkg.sv
// Shared types and mode encodings for the pm_sched request scheduler.
package pm_sched_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    GRANT   = 2'b01,
    RELEASE = 2'b10
  } state_t;

  localparam logic [1:0] MODE_RR   = 2'b00;  // round-robin
  localparam logic [1:0] MODE_FIX  = 2'b01;  // fixed priority, lowest index wins
  localparam logic [1:0] MODE_SHOT = 2'b10;  // single grant until en drops
  localparam logic [1:0] MODE_OFF  = 2'b11;  // no new grants

endpackage

// File: rtl/pm_rr_pick.sv
// Combinational rotating-priority picker: first set request at or after
// ptr_i, wrapping from N_CH-1 to 0. ptr_i tied to zero gives fixed priority.
module pm_rr_pick #(
  parameter int unsigned N_CH = 4,
  parameter int unsigned IDW  = $clog2(N_CH)
) (
  input  logic [N_CH-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [N_CH-1:0] onehot_o,
  output logic [IDW-1:0]  idx_o,
  output logic            valid_o
);

  logic [IDW-1:0] j;

  // Scan channels in rotated order and keep the first requester found.
  always_comb begin
    onehot_o = '0;
    idx_o    = '0;
    valid_o  = 1'b0;
    j        = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      j = IDW'((32'(ptr_i) + i) % N_CH);
      if (!valid_o && req_i[j]) begin
        valid_o     = 1'b1;
        onehot_o[j] = 1'b1;
        idx_o       = j;
      end
    end
  end

endmodule

// File: rtl/pm_sched.sv
// N-channel request scheduler: grant FSM, per-grant hold counter, timeout and
// protocol-error pulses, round-robin / fixed / single-shot arbitration.
module pm_sched #(
  parameter int unsigned N_CH     = 4,
  parameter int unsigned HOLD_MAX = 15,
  parameter int unsigned IDW      = $clog2(N_CH),
  parameter int unsigned CW       = $clog2(HOLD_MAX + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            lock,
  input  logic [1:0]      mode,
  input  logic [N_CH-1:0] req,
  input  logic            done,
  output logic [N_CH-1:0] grant,
  output logic [IDW-1:0]  grant_id,
  output logic            busy,
  output logic            timeout,
  output logic            err
);

  import pm_sched_pkg::*;

  state_t          state_q;
  logic [N_CH-1:0] grant_q;
  logic [IDW-1:0]  id_q;
  logic            busy_q;
  logic            timeout_q;
  logic            err_q;
  logic [CW-1:0]   cnt_q;
  logic [IDW-1:0]  ptr_q;
  logic            shot_q;
  logic [1:0]      gmode_q;   // mode latched at grant time

  logic [IDW-1:0]  ptr_d;
  logic            shot_d;
  logic [IDW-1:0]  pick_ptr;
  logic [N_CH-1:0] pick_onehot;
  logic [IDW-1:0]  pick_idx;
  logic            pick_valid;
  logic            can_grant;
  logic            req_w;
  logic            cnt_max;
  logic            g_exit;

  // Pointer and shot flag as they stand after this cycle. RELEASE doubles as
  // an arbitration slot, so its decision must already see the advanced
  // pointer and the set shot flag; this keeps the gap between grants at one.
  always_comb begin
    ptr_d = ptr_q;
    if (state_q == RELEASE && gmode_q == MODE_RR) begin
      ptr_d = (id_q == IDW'(N_CH - 1)) ? '0 : id_q + IDW'(1);
    end
    shot_d = en & (shot_q | (state_q == RELEASE && gmode_q == MODE_SHOT));
  end

  // Rotating start point only in round-robin; every other mode scans from 0.
  always_comb begin
    case (mode)
      MODE_RR:             pick_ptr = ptr_d;
      MODE_FIX, MODE_SHOT: pick_ptr = '0;
      default:             pick_ptr = '0;
    endcase
  end

  pm_rr_pick #(
    .N_CH (N_CH),
    .IDW  (IDW)
  ) u_pick (
    .req_i    (req),
    .ptr_i    (pick_ptr),
    .onehot_o (pick_onehot),
    .idx_o    (pick_idx),
    .valid_o  (pick_valid)
  );

  // Grant admission and exit conditions for the FSM.
  always_comb begin
    can_grant = (state_q != GRANT) && en && !lock && (mode != MODE_OFF) &&
                pick_valid && !(mode == MODE_SHOT && shot_d);
    req_w     = |(req & grant_q);
    cnt_max   = (cnt_q == CW'(HOLD_MAX));
    g_exit    = !en || done || !req_w || cnt_max;
  end

  // Grant FSM with counter, pointer, shot flag and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      id_q      <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
      ptr_q     <= '0;
      shot_q    <= 1'b0;
      gmode_q   <= MODE_RR;
    end else begin
      ptr_q     <= ptr_d;
      shot_q    <= shot_d;
      timeout_q <= 1'b0;
      err_q     <= 1'b0;
      case (state_q)
        IDLE, RELEASE: begin
          cnt_q <= '0;
          if (can_grant) begin
            state_q <= GRANT;
            grant_q <= pick_onehot;
            id_q    <= pick_idx;
            busy_q  <= 1'b1;
            cnt_q   <= CW'(1);
            gmode_q <= mode;
          end else begin
            state_q <= IDLE;
            grant_q <= '0;
            busy_q  <= 1'b0;
          end
        end
        GRANT: begin
          if (g_exit) begin
            state_q   <= RELEASE;
            grant_q   <= '0;
            busy_q    <= 1'b1;
            cnt_q     <= '0;
            err_q     <= en && !done && !req_w;
            timeout_q <= en && !done && req_w && cnt_max;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          grant_q <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign grant    = grant_q;
  assign grant_id = id_q;
  assign busy     = busy_q;
  assign timeout  = timeout_q;
  assign err      = err_q;

endmodule

// File: tb/tb_pm_sched.sv
// Bench for pm_sched (N_CH=4, HOLD_MAX=3): directed stimulus with expected
// outputs queued per cycle and compared by a negedge monitor.
module tb_pm_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       lock;
  logic [1:0] mode;
  logic [3:0] req;
  logic       done;
  logic [3:0] grant;
  logic [1:0] grant_id;
  logic       busy;
  logic       timeout;
  logic       err;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned cyc_n   = 0;

  typedef struct {
    string       tag;
    int unsigned due;
    logic [8:0]  v;   // {grant, grant_id, busy, timeout, err}
  } exp_t;

  exp_t exp_q[$];

  pm_sched #(
    .N_CH     (4),
    .HOLD_MAX (3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .lock     (lock),
    .mode     (mode),
    .req      (req),
    .done     (done),
    .grant    (grant),
    .grant_id (grant_id),
    .busy     (busy),
    .timeout  (timeout),
    .err      (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc_n);
    end
  endtask

  // Compare every expectation that falls due in the cycle just completed.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].due <= cyc_n) begin
      exp_t e;
      e = exp_q.pop_front();
      chk(e.tag, 32'({grant, grant_id, busy, timeout, err}), 32'(e.v));
    end
  end

  // Queue the outputs expected after the next edge, then advance one cycle.
  task automatic tick(input string tag, input logic [3:0] g, input logic [1:0] id,
                      input logic b, input logic t, input logic e);
    exp_t x;
    x.tag = tag;
    x.due = cyc_n + 1;
    x.v   = {g, id, b, t, e};
    exp_q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] ch;
    logic [3:0] g;
    rst = 1'b1; en = 1'b0; lock = 1'b0; mode = 2'b00; req = '0; done = 1'b0;
    @(posedge clk);
    #1;
    tick("reset0", 4'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    tick("reset1", 4'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    // Round-robin over all four channels, done two cycles after each grant.
    en = 1'b1; mode = 2'b00; req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      ch = 2'(k % 4);
      g  = 4'b0001 << ch;
      tick("rr_grant", g, ch, 1'b1, 1'b0, 1'b0);
      if (k == 4) break;
      tick("rr_hold", g, ch, 1'b1, 1'b0, 1'b0);
      done = 1'b1;
      tick("rr_rel", 4'b0, ch, 1'b1, 1'b0, 1'b0);
      done = 1'b0;
    end
    en = 1'b0;
    tick("rr_abort", 4'b0, 2'd0, 1'b1, 1'b0, 1'b0);
    tick("rr_idle", 4'b0, 2'd0, 1'b0, 1'b0, 1'b0);

    // Fixed priority: channel 1 always wins against channel 3.
    en = 1'b1; mode = 2'b01; req = 4'b1010;
    for (int k = 0; k < 3; k++) begin
      tick("fix_grant", 4'b0010, 2'd1, 1'b1, 1'b0, 1'b0);
      tick("fix_hold", 4'b0010, 2'd1, 1'b1, 1'b0, 1'b0);
      done = 1'b1;
      tick("fix_rel", 4'b0, 2'd1, 1'b1, 1'b0, 1'b0);
      done = 1'b0;
    end
    tick("fix_grant", 4'b0010, 2'd1, 1'b1, 1'b0, 1'b0);
    en = 1'b0;
    tick("en_abort", 4'b0, 2'd1, 1'b1, 1'b0, 1'b0);
    tick("en_idle", 4'b0, 2'd1, 1'b0, 1'b0, 1'b0);

    // Forced release after HOLD_MAX=3 cycles, then immediate regrant.
    en = 1'b1; mode = 2'b00; req = 4'b0100;
    tick("to_c1", 4'b0100, 2'd2, 1'b1, 1'b0, 1'b0);
    tick("to_c2", 4'b0100, 2'd2, 1'b1, 1'b0, 1'b0);
    tick("to_c3", 4'b0100, 2'd2, 1'b1, 1'b0, 1'b0);
    tick("to_pulse", 4'b0, 2'd2, 1'b1, 1'b1, 1'b0);
    tick("to_regrant", 4'b0100, 2'd2, 1'b1, 1'b0, 1'b0);
    en = 1'b0;
    tick("to_abort", 4'b0, 2'd2, 1'b1, 1'b0, 1'b0);
    tick("to_idle", 4'b0, 2'd2, 1'b0, 1'b0, 1'b0);

    // Request drop without done gives err; with done it does not.
    en = 1'b1; mode = 2'b01; req = 4'b0010;
    tick("err_grant", 4'b0010, 2'd1, 1'b1, 1'b0, 1'b0);
    tick("err_hold", 4'b0010, 2'd1, 1'b1, 1'b0, 1'b0);
    req = 4'b0000;
    tick("err_pulse", 4'b0, 2'd1, 1'b1, 1'b0, 1'b1);
    tick("err_idle", 4'b0, 2'd1, 1'b0, 1'b0, 1'b0);
    req = 4'b0010;
    tick("dd_grant", 4'b0010, 2'd1, 1'b1, 1'b0, 1'b0);
    done = 1'b1; req = 4'b0000;
    tick("dd_noerr", 4'b0, 2'd1, 1'b1, 1'b0, 1'b0);
    done = 1'b0;
    tick("dd_idle", 4'b0, 2'd1, 1'b0, 1'b0, 1'b0);

    // done coinciding with counter at HOLD_MAX: no timeout.
    req = 4'b0010;
    tick("dt_c1", 4'b0010, 2'd1, 1'b1, 1'b0, 1'b0);
    tick("dt_c2", 4'b0010, 2'd1, 1'b1, 1'b0, 1'b0);
    tick("dt_c3", 4'b0010, 2'd1, 1'b1, 1'b0, 1'b0);
    done = 1'b1;
    tick("dt_noto", 4'b0, 2'd1, 1'b1, 1'b0, 1'b0);
    done = 1'b0; req = 4'b0000;
    tick("dt_idle", 4'b0, 2'd1, 1'b0, 1'b0, 1'b0);

    // Single shot: one grant until en drops for a cycle.
    mode = 2'b10; req = 4'b0001;
    tick("shot_grant", 4'b0001, 2'd0, 1'b1, 1'b0, 1'b0);
    tick("shot_hold", 4'b0001, 2'd0, 1'b1, 1'b0, 1'b0);
    done = 1'b1;
    tick("shot_rel", 4'b0, 2'd0, 1'b1, 1'b0, 1'b0);
    done = 1'b0;
    tick("shot_used0", 4'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    tick("shot_used1", 4'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    tick("shot_used2", 4'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    en = 1'b0;
    tick("shot_clr", 4'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    en = 1'b1;
    tick("shot_again", 4'b0001, 2'd0, 1'b1, 1'b0, 1'b0);
    done = 1'b1;
    tick("shot_rel2", 4'b0, 2'd0, 1'b1, 1'b0, 1'b0);
    done = 1'b0;
    tick("shot_used3", 4'b0, 2'd0, 1'b0, 1'b0, 1'b0);

    // Disabled mode and lock block new grants; lock mid-grant does not.
    mode = 2'b11; req = 4'b1111;
    tick("off0", 4'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    tick("off1", 4'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    mode = 2'b00; lock = 1'b1;
    tick("lock0", 4'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    tick("lock1", 4'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    lock = 1'b0;
    tick("lk_grant", 4'b1000, 2'd3, 1'b1, 1'b0, 1'b0);
    lock = 1'b1;
    tick("lk_hold", 4'b1000, 2'd3, 1'b1, 1'b0, 1'b0);
    done = 1'b1;
    tick("lk_rel", 4'b0, 2'd3, 1'b1, 1'b0, 1'b0);
    done = 1'b0;
    tick("lk_idle", 4'b0, 2'd3, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of a grant.
    lock = 1'b0; req = 4'b0100;
    tick("rs_grant", 4'b0100, 2'd2, 1'b1, 1'b0, 1'b0);
    tick("rs_hold", 4'b0100, 2'd2, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    tick("rs_mid", 4'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0; en = 1'b0;
    tick("rs_after", 4'b0, 2'd0, 1'b0, 1'b0, 1'b0);

    @(negedge clk);
    #1;
    chk("drain", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
